// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over four requesters that owns a shared 4:1 data mux.
// Grant and select are registered; valid/out are combinational from them.
module rr_mux_arbiter #(
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [3:0]        grant,
  output logic [1:0]        sel,
  output logic              valid,
  output logic [DATA_W-1:0] out
);

  localparam logic [CNT_W-1:0] MaxBurstCnt = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] OneCnt      = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       win;

  // Returns {found, index} of the first request at or after start, circularly.
  function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    win     = 3'b000;
    unique case (state_q)
      StIdle: begin
        win = search(req, ptr_q);
        if (win[2]) begin
          grant_d = 4'b0001 << win[1:0];
          sel_d   = win[1:0];
          cnt_d   = OneCnt;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (req[sel_q] && (cnt_q < MaxBurstCnt)) begin
          cnt_d = cnt_q + OneCnt;
        end else begin
          // Previous owner goes to the back of the circular order.
          ptr_d = sel_q + 2'd1;
          win   = search(req, sel_q + 2'd1);
          if (win[2]) begin
            grant_d = 4'b0001 << win[1:0];
            sel_d   = win[1:0];
            cnt_d   = OneCnt;
          end else begin
            grant_d = 4'b0000;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = |(grant_q & req);

  always_comb begin
    out = '0;
    if (valid) begin
      unique case (sel_q)
        2'd0: out = in0;
        2'd1: out = in1;
        2'd2: out = in2;
        2'd3: out = in3;
        default: out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: two instances (burst 4 and burst 1) share
// stimulus; a queue-based reference model predicts grant/sel/valid/out per cycle.
module tb_rr_mux_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] in0, in1, in2, in3;

  logic [3:0]    grant_a, grant_b;
  logic [1:0]    sel_a, sel_b;
  logic          valid_a, valid_b;
  logic [DW-1:0] out_a, out_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]    grant;
    logic [1:0]    sel;
    logic          valid;
    logic [DW-1:0] out;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Reference model: owner = -1 when idle; last = most recent owner index.
  int owner[2];
  int last[2];
  int ptr[2];
  int burst[2];
  int maxb[2];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.DATA_W(DW), .MAX_BURST(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .req(req), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .grant(grant_a), .sel(sel_a), .valid(valid_a), .out(out_a)
  );

  rr_mux_arbiter #(.DATA_W(DW), .MAX_BURST(1), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .req(req), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .grant(grant_b), .sel(sel_b), .valid(valid_b), .out(out_b)
  );

  function automatic int find(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    case (i)
      0: return in0;
      1: return in1;
      2: return in2;
      default: return in3;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1;
      last[i]  = 0;
      ptr[i]   = 0;
      burst[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [3:0] r);
    int n;
    if (owner[i] < 0) begin
      n = find(r, ptr[i]);
      if (n >= 0) begin
        owner[i] = n;
        last[i]  = n;
        burst[i] = 1;
      end
    end else if (r[owner[i]] && burst[i] < maxb[i]) begin
      burst[i]++;
    end else begin
      ptr[i] = (owner[i] + 1) % 4;
      n = find(r, ptr[i]);
      if (n >= 0) begin
        owner[i] = n;
        last[i]  = n;
        burst[i] = 1;
      end else begin
        owner[i] = -1;
        burst[i] = 0;
      end
    end
  endtask

  function automatic exp_t predict(input int i);
    exp_t e;
    e.sel   = 2'(last[i]);
    e.grant = (owner[i] >= 0) ? 4'(1 << owner[i]) : 4'b0000;
    e.valid = (owner[i] >= 0) && req[owner[i]];
    e.out   = e.valid ? data_of(owner[i]) : '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic rand_data();
    in0 = DW'($urandom);
    in1 = DW'($urandom);
    in2 = DW'($urandom);
    in3 = DW'($urandom);
  endtask

  // One clock: model consumes the req sampled at the edge, then new inputs are driven.
  task automatic step(input logic [3:0] nreq);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) model_step(i, req);
    req = nreq;
    rand_data();
    exp_q0.push_back(predict(0));
    exp_q1.push_back(predict(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant_a"}, 32'(grant_a), 32'h0);
    chk({tag, "_sel_a"},   32'(sel_a),   32'h0);
    chk({tag, "_valid_a"}, 32'(valid_a), 32'h0);
    chk({tag, "_out_a"},   32'(out_a),   32'h0);
    chk({tag, "_grant_b"}, 32'(grant_b), 32'h0);
    chk({tag, "_valid_b"}, 32'(valid_b), 32'h0);
  endtask

  // Monitor: compares every cycle for which the stimulus pushed an expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        chk("a_grant", 32'(grant_a), 32'(e.grant));
        chk("a_sel",   32'(sel_a),   32'(e.sel));
        chk("a_valid", 32'(valid_a), 32'(e.valid));
        chk("a_out",   32'(out_a),   32'(e.out));
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        chk("b_grant", 32'(grant_b), 32'(e.grant));
        chk("b_sel",   32'(sel_b),   32'(e.sel));
        chk("b_valid", 32'(valid_b), 32'(e.valid));
        chk("b_out",   32'(out_b),   32'(e.out));
      end
    end
  end

  initial begin
    logic [3:0] r;
    maxb[0] = 4;
    maxb[1] = 1;
    model_reset();
    rst = 1'b1;
    req = 4'b1111;
    rand_data();
    #3;
    chk_reset_outputs("reset_init");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset_held");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // All four requesting: burst-4 rotation, burst-1 rotation every cycle.
    repeat (22) step(4'b1111);
    // Sole requester 2, including self re-grant at burst expiry, then drop.
    repeat (10) step(4'b0100);
    repeat (3) step(4'b0000);
    // Owner drops early while others wait.
    step(4'b0010);
    step(4'b0010);
    step(4'b1011);
    step(4'b1001);
    repeat (6) step(4'b1001);
    // Alternating pair.
    repeat (8) step(4'b0101);

    // Mid-burst async reset with owner 2.
    step(4'b0000);
    step(4'b0000);
    repeat (3) step(4'b0100);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset_async");
    model_reset();
    req = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (6) step(4'b0110);

    // Randomised traffic biased towards busy requesters.
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) r = 4'b0000;
      step(r);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
